// File: rtl/axis_fifo_pkg.sv
// Shared constants and types for the AXIS FIFO read-side master.
package axis_fifo_pkg;

  localparam int BUF_DEPTH      = 3;
  localparam int DEF_FIFO_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } axis_rd_state_t;

endpackage

// File: rtl/axis_fifo_rd_master_if.sv
// AXI-Stream bundle driven by the FIFO read-side master.
// Valid/ready: a beat transfers on a rising edge where tvalid && tready; once tvalid is
// raised, tdata/tlast stay stable and tvalid stays high until that transfer happens.
interface axis_fifo_rd_master_if
  import axis_fifo_pkg::*;
#(
  parameter int W = DEF_FIFO_WIDTH
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_rd_skid_buf.sv
// Three-entry circular buffer holding FIFO words between capture and the stream handshake.
module axis_rd_skid_buf
  import axis_fifo_pkg::*;
#(
  parameter int W = DEF_FIFO_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head_data
);

  logic [W-1:0] mem_q [BUF_DEPTH];
  logic [W-1:0] mem_d [BUF_DEPTH];
  logic [1:0]   wr_ptr_q, wr_ptr_d;
  logic [1:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]   occ_q, occ_d;
  logic         do_pop;

  // Pointers run 0,1,2,0,... so a 2-bit register never visits 3.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    do_pop   = pop && (occ_q != 2'd0);
    if (push) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (wr_ptr_q == 2'(i)) mem_d[i] = push_data;
      end
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, do_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    head_data = '0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (rd_ptr_q == 2'(i)) head_data = mem_q[i];
    end
  end

  assign occ = occ_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      occ_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/axis_fifo_rd_master.sv
// Read-side AXI-Stream master: pops FIFO words into a 3-entry buffer and frames them into packets.
// Optional AXIS_RD_STATS_EN adds beat_cnt/pkt_cnt outputs.
module axis_fifo_rd_master
  import axis_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int LEN_W      = 8
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  input  logic [LEN_W-1:0]      pkt_len,
  axis_fifo_rd_master_if.master m_axis,
  output axis_rd_state_t        dbg_state
`ifdef AXIS_RD_STATS_EN
  ,
  output logic [31:0]           beat_cnt,
  output logic [31:0]           pkt_cnt
`endif
);

  axis_rd_state_t        state_q, state_d;
  logic [LEN_W-1:0]      cur_len_q, cur_len_d;
  logic [LEN_W-1:0]      beat_idx_q, beat_idx_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ;
  logic [FIFO_WIDTH-1:0] head_data;
  logic [2:0]            committed;
  logic                  tvalid, tlast, hs;

  axis_rd_skid_buf #(.W(FIFO_WIDTH)) u_buf (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .push      (inflight_q),
    .push_data (fifo_rd_data),
    .pop       (hs),
    .occ       (occ),
    .head_data (head_data)
  );

  // Slots already spoken for: buffered words plus the word arriving next cycle.
  always_comb begin
    committed  = {1'b0, occ} + {2'b00, inflight_q};
    fifo_rd_en = !rd_rst && !fifo_empty && (committed < 3'(BUF_DEPTH));
    tvalid     = (occ != 2'd0);
    tlast      = tvalid && (beat_idx_q == (cur_len_q - LEN_W'(1)));
    hs         = tvalid && m_axis.tready;
  end

  assign m_axis.tdata  = head_data;
  assign m_axis.tvalid = tvalid;
  assign m_axis.tlast  = tlast;
  assign dbg_state     = state_q;

  always_comb begin
    state_d    = state_q;
    cur_len_d  = cur_len_q;
    beat_idx_d = beat_idx_q;
    inflight_d = fifo_rd_en;
    case (state_q)
      IDLE: begin
        // Length is only sampled while nothing is presented, so tlast cannot move under tvalid.
        if (!tvalid) cur_len_d = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
        if (hs && !tlast) state_d = PKT;
      end
      PKT: begin
        if (hs && tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (hs) beat_idx_d = tlast ? '0 : beat_idx_q + LEN_W'(1);
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q    <= IDLE;
      cur_len_q  <= LEN_W'(1);
      beat_idx_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_len_q  <= cur_len_d;
      beat_idx_q <= beat_idx_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef AXIS_RD_STATS_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic [31:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (hs) beat_cnt_d = beat_cnt_q + 32'd1;
    if (hs && tlast) pkt_cnt_d = pkt_cnt_q + 32'd1;
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      beat_cnt_q <= 32'd0;
      pkt_cnt_q  <= 32'd0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
  assign pkt_cnt  = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axis_fifo_rd_master.sv
// Bench for axis_fifo_rd_master: FIFO model with 1-cycle read latency, expected-word queue, packet-position model.
module tb_axis_fifo_rd_master;
  import axis_fifo_pkg::*;

  localparam int W  = 32;
  localparam int LW = 8;

  // ---------------- clock / reset ----------------
  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_rd_data = '0;
  logic          fifo_rd_en;
  logic [LW-1:0] pkt_len = 8'd8;
  axis_rd_state_t dbg_state;
`ifdef AXIS_RD_STATS_EN
  logic [31:0]   beat_cnt, pkt_cnt;
`endif

  axis_fifo_rd_master_if #(.W(W)) m_axis ();

  axis_fifo_rd_master #(.FIFO_WIDTH(W), .LEN_W(LW)) dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .pkt_len      (pkt_len),
    .m_axis       (m_axis),
    .dbg_state    (dbg_state)
`ifdef AXIS_RD_STATS_EN
    ,
    .beat_cnt     (beat_cnt),
    .pkt_cnt      (pkt_cnt)
`endif
  );

  always #5 rd_clk = ~rd_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model / scoreboard state ----------------
  logic [W-1:0] mfifo[$];   // contents of the upstream FIFO
  logic [W-1:0] exp_q[$];   // words popped from the FIFO, not yet seen on the stream
  int      model_len = 8;
  int      beat_in_pkt = 0;
  longint  model_beats = 0, model_pkts = 0;
  int      n_checks = 0, n_fail = 0;
  int      cyc = 0;
  bit      force_empty = 0;
  int      rd_pulses = 0, first_hs = -1, last_hs = -1, hs_cnt = 0, gap_cnt = 0;
  bit      last_rd_en = 0;
  bit      hold_valid = 0;
  logic [W-1:0] hold_data = '0;
  logic    hold_last = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver: one clock cycle, called at negedge ----------------
  task automatic cycle();
    bit           new_pend;
    logic [W-1:0] new_word;
    logic [W-1:0] w;
    logic         tv, tl;
    logic [W-1:0] td;
    fifo_empty = force_empty || (mfifo.size() == 0);
    #1;
    tv = m_axis.tvalid;
    td = m_axis.tdata;
    tl = m_axis.tlast;
    new_pend = 0;
    new_word = '0;
    if (!rd_rst) begin
      if (hold_valid) begin
        check("axis_hold_valid", 64'(tv), 64'd1);
        check("axis_hold_data", 64'(td), 64'(hold_data));
        check("axis_hold_last", 64'(tl), 64'(hold_last));
      end
      hold_valid = tv && !m_axis.tready;
      hold_data  = td;
      hold_last  = tl;
      if (tv && m_axis.tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          w = exp_q.pop_front();
          check("tdata", 64'(td), 64'(w));
          check("tlast", 64'(tl), 64'(beat_in_pkt == model_len - 1));
        end
        model_beats++;
        if (beat_in_pkt == model_len - 1) begin
          beat_in_pkt = 0;
          model_pkts++;
        end else begin
          beat_in_pkt++;
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        hs_cnt++;
      end else if (!tv && first_hs >= 0 && mfifo.size() != 0) begin
        gap_cnt++;
      end
    end
    last_rd_en = fifo_rd_en;
    if (fifo_rd_en) begin
      rd_pulses++;
      if (rd_rst || fifo_empty) begin
        check("rd_en_when_blocked", 64'd1, 64'd0);
      end else begin
        new_word = mfifo.pop_front();
        exp_q.push_back(new_word);
        new_pend = 1;
      end
    end
    @(posedge rd_clk);
    if (rd_rst) begin
      exp_q.delete();
      beat_in_pkt = 0;
      model_beats = 0;
      model_pkts  = 0;
      hold_valid  = 0;
    end
    @(negedge rd_clk);
    fifo_rd_data = new_pend ? new_word : W'($urandom());
    cyc++;
  endtask

  task automatic load_seq(input int n, input int base);
    for (int i = 0; i < n; i++) mfifo.push_back(W'(base + i));
  endtask

  task automatic load_rand(input int n);
    for (int i = 0; i < n; i++) mfifo.push_back(W'($urandom()));
  endtask

  // Only called with the stream idle, so the new length is in force for the next packet.
  task automatic set_len(input int n);
    pkt_len   = LW'(n);
    model_len = (n == 0) ? 1 : n;
    cycle();
  endtask

  task automatic reset_phase_counters();
    first_hs  = -1;
    last_hs   = -1;
    hs_cnt    = 0;
    gap_cnt   = 0;
    rd_pulses = 0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    m_axis.tready = 1'b1;
    force_empty   = 0;
    while ((mfifo.size() != 0 || exp_q.size() != 0) && n < 300) begin
      cycle();
      n++;
    end
    check({tag, "_drained"}, 64'(mfifo.size() == 0 && exp_q.size() == 0), 64'd1);
    repeat (3) cycle();
    check({tag, "_idle_tvalid"}, 64'(m_axis.tvalid), 64'd0);
`ifdef AXIS_RD_STATS_EN
    check({tag, "_beat_cnt"}, 64'(beat_cnt), 64'(model_beats[31:0]));
    check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(model_pkts[31:0]));
`endif
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    m_axis.tready = 1'b1;
    force_empty   = 0;
    @(negedge rd_clk);

    // Reset held with a non-empty FIFO and a ready sink.
    load_seq(4, 100);
    cycle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
      check("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
      check("rst_tlast", 64'(m_axis.tlast), 64'd0);
      check("rst_tdata", 64'(m_axis.tdata), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(IDLE));
    end
`ifdef AXIS_RD_STATS_EN
    check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
    mfifo.delete();
    rd_rst = 1'b0;
    repeat (3) cycle();
    check("post_rst_tvalid", 64'(m_axis.tvalid), 64'd0);

    // Preloaded 0..31, pkt_len 8: 2-cycle latency then 32 back-to-back beats.
    set_len(8);
    reset_phase_counters();
    load_seq(32, 0);
    n = cyc;
    repeat (40) cycle();
    check("t2_latency", 64'(first_hs - n), 64'd2);
    check("t2_no_bubbles", 64'(last_hs - first_hs), 64'd31);
    check("t2_beats", 64'(hs_cnt), 64'd32);
    drain("t2");

    // Backpressure: three pops fill the buffer, then reads stop and the head holds.
    reset_phase_counters();
    m_axis.tready = 1'b0;
    load_seq(8, 200);
    repeat (10) cycle();
    check("t3_rd_pulses", 64'(rd_pulses), 64'd3);
    check("t3_tvalid", 64'(m_axis.tvalid), 64'd1);
    check("t3_head", 64'(m_axis.tdata), 64'(exp_q[0]));
    drain("t3");

    // Empty flag toggling every 3 cycles, pkt_len 4.
    set_len(4);
    reset_phase_counters();
    load_rand(24);
    n = 0;
    while (mfifo.size() != 0 && n < 200) begin
      force_empty = ((cyc / 3) % 2) == 0;
      cycle();
      n++;
    end
    force_empty = 0;
    check("t4_gaps_seen", 64'(gap_cnt > 0), 64'd1);
    drain("t4");

    // pkt_len 0 behaves as 1.
    set_len(0);
    load_rand(5);
    drain("t5a");

    // pkt_len changed mid-packet: current packet keeps its length.
    set_len(4);
    reset_phase_counters();
    load_seq(4, 300);
    n = 0;
    while (hs_cnt < 2 && n < 50) begin
      cycle();
      n++;
    end
    check("t5_two_beats", 64'(hs_cnt), 64'd2);
    pkt_len = 8'd2;
    drain("t5b");
    check("t5b_state", 64'(dbg_state), 64'(IDLE));
    set_len(2);
    load_seq(4, 400);
    drain("t5c");

    // Randomized rounds: random length, backpressure and empty gaps.
    for (int r = 0; r < 8; r++) begin
      set_len($urandom_range(0, 5));
      load_rand(model_len * $urandom_range(1, 4));
      n = 0;
      while ((mfifo.size() != 0 || exp_q.size() != 0) && n < 400) begin
        m_axis.tready = ($urandom_range(0, 3) != 0);
        force_empty   = ($urandom_range(0, 4) == 0);
        cycle();
        n++;
      end
      drain("rand");
      check("rand_state", 64'(dbg_state), 64'(IDLE));
    end

    // Reset after 3 beats of an 8-beat packet with a read in flight.
    set_len(8);
    reset_phase_counters();
    load_rand(20);
    n = 0;
    while (hs_cnt < 3 && n < 50) begin
      cycle();
      n++;
    end
    check("t6_three_beats", 64'(hs_cnt), 64'd3);
    check("t6_read_in_flight", 64'(last_rd_en), 64'd1);
    rd_rst = 1'b1;
    cycle();
    rd_rst = 1'b0;
    check("t6_tvalid_after_rst", 64'(m_axis.tvalid), 64'd0);
`ifdef AXIS_RD_STATS_EN
    check("t6_beat_cnt_rst", 64'(beat_cnt), 64'd0);
    check("t6_pkt_cnt_rst", 64'(pkt_cnt), 64'd0);
`endif
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
